// File: rtl/seq_detect_pkg.sv
// Shared definitions for the 0-1-1-1-0 serial pattern detector:
// state encodings, the pattern constant and its length.
package seq_detect_pkg;

  localparam int STATE_W = 3;
  localparam int PAT_LEN = 5;
  localparam logic [PAT_LEN-1:0] PATTERN = 5'b01110;

  // Each state name spells the prefix of PATTERN matched so far.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_0    = 3'd1,
    S_01   = 3'd2,
    S_011  = 3'd3,
    S_0111 = 3'd4
  } state_e;

endpackage

// File: rtl/seq_detect_01110_sat_counter.sv
// CNT_W-bit saturating up-counter with synchronous active-low reset and a
// synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  // NOTE: sequential state is always updated with <= so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!clr) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_01110.sv
// Serial 0-1-1-1-0 detector with registered match pulse and saturating count.
// Define SEQ_DETECT_NOOVERLAP_EN to stop the trailing 0 seeding the next match.
module seq_detect_01110
  import seq_detect_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             din,
  input  logic             din_vld,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [2:0]       state
);

  state_e state_q;
  state_e state_d;
  logic   hit;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      match   <= 1'b0;
    end else begin
      state_q <= state_d;
      match   <= hit;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    case (state_q)
      S_IDLE: if (din_vld) state_d = din ? S_IDLE : S_0;
      S_0:    if (din_vld) state_d = din ? S_01   : S_0;
      S_01:   if (din_vld) state_d = din ? S_011  : S_0;
      S_011:  if (din_vld) state_d = din ? S_0111 : S_0;
      S_0111: begin
        if (din_vld) begin
          if (din) begin
            state_d = S_IDLE;
          end else begin
            hit = 1'b1;
`ifdef SEQ_DETECT_NOOVERLAP_EN
            state_d = S_IDLE;
`else
            state_d = S_0;
`endif
          end
        end
      end
      // Codes 5-7 recover to idle on the next edge, valid strobe or not.
      default: state_d = S_IDLE;
    endcase
  end

  assign state = state_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .clr   (clr),
    .clear (cnt_clr),
    .inc   (hit),
    .count (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_01110.sv
// Bench for seq_detect_01110: directed vector table plus random stream checked
// against a bit-history reference model; a CNT_W=2 copy exercises saturation.
module tb_seq_detect_01110;

  logic       clk = 1'b0;
  logic       clr, din, din_vld, cnt_clr;
  logic       match8, match2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  logic [2:0] state8, state2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_01110 #(.CNT_W(8)) dut8 (
    .clk(clk), .clr(clr), .din(din), .din_vld(din_vld), .cnt_clr(cnt_clr),
    .match(match8), .match_cnt(cnt8), .state(state8)
  );

  seq_detect_01110 #(.CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .din(din), .din_vld(din_vld), .cnt_clr(cnt_clr),
    .match(match2), .match_cnt(cnt2), .state(state2)
  );

  // Reference model: recent valid bits, how many are usable, and the counts.
  logic [4:0] hv;
  int         n;
  logic       m_match;
  int         m_cnt8, m_cnt2;
  logic [2:0] m_state;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic c, input logic d, input logic v, input logic cc);
    logic [4:0] pat;
    logic       ok;
    pat = 5'b01110;
    if (!c) begin
      hv = '0; n = 0; m_match = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      m_match = 1'b0;
      if (v) begin
        hv = {hv[3:0], d};
        if (n < 5) n++;
        if (n == 5 && hv == pat) begin
          m_match = 1'b1;
`ifdef SEQ_DETECT_NOOVERLAP_EN
          n = 0;
`endif
        end
      end
      if (cc) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (m_match) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    // State = length of the longest usable suffix that is a pattern prefix.
    m_state = 3'd0;
    for (int k = 1; k <= 4; k++) begin
      if (n >= k) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (hv[k-1-j] !== pat[4-j]) ok = 1'b0;
        if (ok) m_state = 3'(k);
      end
    end
  endtask

  task automatic step(input logic c, input logic d, input logic v, input logic cc);
    clr = c; din = d; din_vld = v; cnt_clr = cc;
    @(posedge clk);
    #1;
    model_update(c, d, v, cc);
    check("model match8", match8, m_match);
    check("model match2", match2, m_match);
    check("model state8", state8, m_state);
    check("model state2", state2, m_state);
    check("model cnt8", cnt8, m_cnt8);
    check("model cnt2", cnt2, m_cnt2);
  endtask

  typedef struct {
    logic       c, d, v, cc;
    logic       em;
    logic [2:0] es;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[$];

  task automatic feed_pattern(input logic last_cc);
    logic [4:0] p;
    p = 5'b01110;
    for (int i = 4; i >= 1; i--) step(1'b1, p[i], 1'b1, 1'b0);
    step(1'b1, p[0], 1'b1, last_cc);
  endtask

  initial begin
    int pulses;
    logic [4:0] p;
    logic [8:0] ov;

    // {clr, din, vld, cnt_clr} -> {match, state, cnt8}
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0}); // reset
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0}); // basic 01110
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 8'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'd1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd1}); // near miss 011110
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'd1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 8'd1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 8'd1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'd0}); // cnt_clr, idle bit
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0}); // reset mid-pattern
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 8'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 8'd0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0});

    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].d, tbl[i].v, tbl[i].cc);
      check($sformatf("tbl[%0d] match", i), match8, tbl[i].em);
      check($sformatf("tbl[%0d] state", i), state8, tbl[i].es);
      check($sformatf("tbl[%0d] cnt", i), cnt8, tbl[i].ec);
    end

    // Pattern with three invalid cycles after every bit.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    p = 5'b01110;
    for (int i = 4; i >= 0; i--) begin
      logic [2:0] held;
      step(1'b1, p[i], 1'b1, 1'b0);
      check("gap bit match", match8, (i == 0));
      held = state8;
      for (int g = 0; g < 3; g++) begin
        step(1'b1, 1'($urandom), 1'b0, 1'b0);
        check("gap hold state", state8, held);
        check("gap match low", match8, 1'b0);
      end
    end
    check("gap count", cnt8, 8'd1);

    // Overlap stream 011101110.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    ov = 9'b011101110;
    pulses = 0;
    for (int i = 8; i >= 0; i--) begin
      step(1'b1, ov[i], 1'b1, 1'b0);
      if (match8) pulses++;
    end
`ifdef SEQ_DETECT_NOOVERLAP_EN
    check("overlap pulses", pulses, 1);
    check("overlap count", cnt8, 8'd1);
`else
    check("overlap pulses", pulses, 2);
    check("overlap count", cnt8, 8'd2);
`endif

    // Saturation of the 2-bit counter over 5 disjoint patterns.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      feed_pattern(1'b0);
      check("sat match2", match2, 1'b1);
      check("sat cnt2", cnt2, (k > 3) ? 3 : k);
      check("sat cnt8", cnt8, k);
    end
    feed_pattern(1'b1);
    check("clr+match pulse", match2, 1'b1);
    check("clr+match cnt2", cnt2, 2'd0);
    check("clr+match cnt8", cnt8, 8'd0);

    // Random stream against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(199, 0) != 0),
           1'($urandom),
           ($urandom_range(9, 0) < 7),
           ($urandom_range(49, 0) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_01110.md
Name: seq_detect_01110

Overview:
- Serial pattern detector that sits directly downstream of the 4-bit shift register.
- Consumes one bit per clock, the bit shifted out of Q[0] during right-shift operations, qualified by a valid strobe.
- Detects the pattern 0-1-1-1-0, with the first-received bit first.
- Emits a one-cycle match pulse and keeps a saturating match count for the controller and bench.

Parameters:
- CNT_W, 8, width of match_cnt; the count saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- din  input  1  serial data bit (shifter Q[0]).
- din_vld  input  1  din is sampled only on edges where din_vld=1.
- cnt_clr  input  1  synchronous clear of match_cnt.
- match  output  1  registered pulse, high exactly one cycle per detected pattern.
- match_cnt  output  CNT_W  number of matches since reset or cnt_clr, saturating.
- state  output  3  current FSM state encoding, for debug and verification.

Behaviour:
- Reset (clr=0 at a rising edge):
  - state=S_IDLE, match=0, match_cnt=0.
  - Reset overrides all other inputs, including a match in progress. A partial pattern is discarded.
- FSM encoding: S_IDLE=0, S_0=1, S_01=2, S_011=3, S_0111=4. Codes 5-7 are illegal and go to S_IDLE on the next edge.
- Transitions, evaluated only on edges with din_vld=1:
  - S_IDLE: din=0 -> S_0; din=1 -> S_IDLE.
  - S_0: din=0 -> S_0; din=1 -> S_01.
  - S_01: din=0 -> S_0; din=1 -> S_011.
  - S_011: din=0 -> S_0; din=1 -> S_0111.
  - S_0111: din=0 -> match, next state S_0 (overlap: the trailing 0 is reused as the pattern prefix); din=1 -> S_IDLE.
- din_vld=0: state holds, match=0, match_cnt holds. Gaps of any length between valid bits are transparent.
- match latency: match=1 in the cycle immediately after the edge that samples the final 0; otherwise 0. Back-to-back matches cannot occur closer than 4 valid bits apart.
- match_cnt: increments by 1 on the same edge that sets match.
  - Holds at 2^CNT_W-1 once reached; no wrap.
- cnt_clr=1: match_cnt=0 on that edge.
  - cnt_clr has priority over a simultaneous increment, so that match is not counted.
  - match still pulses.
  - cnt_clr does not affect the FSM.
- Outputs are all registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SEQ_DETECT_NOOVERLAP_EN.
- Defined: on a match from S_0111 the next state is S_IDLE, so the trailing 0 is not reused. Stream 011101110 gives 1 match.
- Undefined (default): overlapping detection as above. Stream 011101110 gives 2 matches.
- No port or parameter changes either way.

Decomposition:
- Package seq_detect_pkg holds:
  - state width and state encodings S_IDLE..S_0111 as localparams;
  - pattern constant PATTERN=5'b01110;
  - PAT_LEN=5.
- One natural sub-module: sat_counter, a parameterised CNT_W saturating counter with sync active-low clr, sync clear and increment enable, with clear priority. It implements match_cnt.
- FSM and match register stay in the top module.

Test Plan:
- Basic match: reset, then din=0,1,1,1,0 with din_vld=1 every cycle -> match=1 only in the cycle after the 5th bit; match_cnt=1; state=S_0 afterwards.
- Overlap: stream 0,1,1,1,0,1,1,1,0 -> match pulses after bits 5 and 9; match_cnt=2. With SEQ_DETECT_NOOVERLAP_EN defined -> single pulse after bit 5; match_cnt=1.
- Near-miss and gaps:
  - Stream 0,1,1,1,1,0 -> no match; state returns to S_IDLE after the 5th bit.
  - Pattern 01110 delivered with din_vld=0 for 3 cycles between each bit -> exactly one match; state held during the gaps.
- Reset mid-sequence: feed 0,1,1,1, drive clr=0 for one edge, then feed 0 -> no match; state=S_0; match_cnt=0.
- Saturation and clear:
  - CNT_W=2, 5 disjoint patterns -> match_cnt reads 1,2,3,3,3; match pulses 5 times.
  - Then assert cnt_clr on the same edge as a 6th match -> match=1, match_cnt=0.
